// File: rtl/spram_lsu.sv
// Load/store initiator for the single-port RAM wrapper: one outstanding byte/half/word access at a time.
// Build option: define SPRAM_LSU_MISALIGN_ERR_EN to reject misaligned/reserved requests with rsp_err instead of force-aligning them.
module spram_lsu #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    state_e            state_q, state_d;
    logic [3:0]        mem_wen_q, mem_wen_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [1:0]  acc_lane, acc_size;
    logic        acc_err;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wen;
    logic [31:0] shifted, load_ext;

    // Request decode: effective lane/size, error flag, replicated write data and byte enables.
    always_comb begin
        acc_lane = req_addr[1:0];
        acc_size = req_size;
        acc_err  = 1'b0;
`ifdef SPRAM_LSU_MISALIGN_ERR_EN
        acc_err = ((req_size == SZ_H) && req_addr[0])
               || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
               || (req_size == SZ_RSV);
`else
        case (req_size)
            SZ_B:    acc_lane = req_addr[1:0];
            SZ_H:    acc_lane = {req_addr[1], 1'b0};
            default: begin
                acc_lane = 2'b00;
                acc_size = SZ_W;
            end
        endcase
`endif
        case (acc_size)
            SZ_B: begin
                acc_wdata = {4{req_wdata[7:0]}};
                acc_wen   = 4'b0001 << acc_lane;
            end
            SZ_H: begin
                acc_wdata = {2{req_wdata[15:0]}};
                acc_wen   = acc_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                acc_wdata = req_wdata;
                acc_wen   = 4'b1111;
            end
        endcase
    end

    // Halfword lanes are always even here, so one byte-granular shift serves both sub-word sizes.
    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            SZ_B:    load_ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // NOTE: every next-state signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        mem_wen_d   = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_d  = req_addr[ADDR_W-1:2];
                    mem_wdata_d = acc_wdata;
                    mem_wen_d   = (req_we && !acc_err) ? acc_wen : 4'b0000;
                    lane_d      = acc_lane;
                    size_d      = acc_size;
                    uns_d       = req_unsigned;
                    we_d        = req_we;
                    err_d       = acc_err;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q || err_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = err_q;
                    state_d     = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_ext;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mem_wen_q   <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            lane_q      <= 2'b00;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign req_ready = resetn && (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_spram_lsu.sv
// Self-checking bench for spram_lsu: byte-level memory model, per-cycle output compare, directed vectors.
module tb_spram_lsu;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [3:0]        mem_wen;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    spram_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SPRAM stand-in: read-first, one-cycle read latency.
    logic [31:0] spram [0:(1<<(ADDR_W-2))-1];
    logic [31:0] spram_q;
    always @(posedge clk) begin
        spram_q <= spram[mem_addr];
        for (int j = 0; j < 4; j++)
            if (mem_wen[j]) spram[mem_addr][8*j +: 8] <= mem_wdata[8*j +: 8];
    end
    assign mem_rdata = spram_q;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory plus the expectations for the access in flight.
    bit [7:0]    ref_mem [0:(1<<ADDR_W)-1];
    logic [3:0]  exp_wen;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic        exp_err;
    int          exp_lat;

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        int n, ea;
        logic mis;
        logic [31:0] v;
        mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0) || size == 2'd3;
        exp_wen = 4'b0000; exp_wdata = 32'h0; exp_rdata = 32'h0; exp_err = 1'b0;
`ifdef SPRAM_LSU_MISALIGN_ERR_EN
        if (mis) begin
            exp_err  = 1'b1;
            exp_lat  = 2;
            exp_addr = 32'(addr) >> 2;
            return;
        end
`else
        if (mis) exp_err = 1'b0;
`endif
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        ea = int'(addr) - (int'(addr) % n);
        exp_addr = 32'(ea / 4);
        if (we) begin
            for (int i = 0; i < n; i++) begin
                exp_wen[(ea % 4) + i] = 1'b1;
                ref_mem[ea + i] = wdata[8*i +: 8];
            end
            for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = wdata[8*(j % n) +: 8];
            exp_lat = 2;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ea + i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
            exp_rdata = v;
            exp_lat   = 3;
        end
    endtask

    logic        active = 1'b0;
    int          k = 0;
    logic [3:0]  iss_wen;
    logic [31:0] iss_addr, iss_wdata, last_rdata;
    logic        last_err;

    // Per-cycle compare; k counts cycles since the accept edge (1 = ISSUE cycle).
    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_mem_wen", mem_wen, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
        end else if (active) begin
            if (k == 1) begin
                iss_wen = mem_wen; iss_addr = 32'(mem_addr); iss_wdata = mem_wdata;
                check("issue_wen", mem_wen, exp_wen);
                check("issue_addr", mem_addr, exp_addr);
                if (exp_wen != 4'b0000) check("issue_wdata", mem_wdata, exp_wdata);
            end else begin
                check("wen_quiet", mem_wen, 0);
            end
            check("req_ready_busy", req_ready, 0);
            if (k >= exp_lat) begin
                check("rsp_valid_on", rsp_valid, 1);
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", rsp_err, exp_err);
            end else begin
                check("rsp_valid_early", rsp_valid, 0);
            end
            k++;
        end else begin
            check("req_ready_idle", req_ready, 1);
            check("rsp_valid_idle", rsp_valid, 0);
            check("wen_idle", mem_wen, 0);
        end
    end

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata, input int hold);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            return;
        end
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        model(we, size, uns, addr, wdata);
        @(posedge clk);
        #1;
        active = 1'b1; k = 1; req_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!rsp_valid && w < 10);
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            active = 1'b0; rsp_ready = 1'b1;
            return;
        end
        check("latency", w, exp_lat);
        last_rdata = rsp_rdata; last_err = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_in_reset", req_ready, 0);
        #2 resetn = 1'b1;

        // Word store then load.
        access(1, 2'd2, 0, 17'h00100, 32'hDEADBEEF, 0);
        check("w_st_wen", iss_wen, 4'b1111);
        check("w_st_addr", iss_addr, 32'h40);
        access(0, 2'd2, 0, 17'h00100, 32'h0, 0);
        check("w_ld", last_rdata, 32'hDEADBEEF);
        check("w_ld_err", last_err, 0);

        // Byte store, signed/unsigned byte loads, neighbours untouched.
        access(1, 2'd0, 0, 17'h00103, 32'h00000080, 0);
        check("b_st_wen", iss_wen, 4'b1000);
        check("b_st_wdata", iss_wdata, 32'h80808080);
        access(0, 2'd0, 0, 17'h00103, 32'h0, 0);
        check("b_ld_s", last_rdata, 32'hFFFFFF80);
        access(0, 2'd0, 1, 17'h00103, 32'h0, 0);
        check("b_ld_u", last_rdata, 32'h00000080);
        access(0, 2'd2, 0, 17'h00100, 32'h0, 0);
        check("b_word_after", last_rdata, 32'h80ADBEEF);

        // Halfword store into upper half.
        access(1, 2'd2, 0, 17'h00200, 32'hAABBCCDD, 0);
        access(1, 2'd1, 0, 17'h00202, 32'h00001234, 0);
        check("h_st_wen", iss_wen, 4'b1100);
        access(0, 2'd1, 0, 17'h00202, 32'h0, 0);
        check("h_ld_s", last_rdata, 32'h00001234);
        access(0, 2'd1, 0, 17'h00200, 32'h0, 0);
        check("h_ld_s_neg", last_rdata, 32'hFFFFCCDD);
        access(0, 2'd2, 0, 17'h00200, 32'h0, 0);
        check("h_word_after", last_rdata, 32'h1234CCDD);

        // Backpressure on a load response, then immediate next access.
        access(0, 2'd2, 0, 17'h00200, 32'h0, 5);
        check("bp_ld", last_rdata, 32'h1234CCDD);
        access(1, 2'd0, 0, 17'h00201, 32'h00000055, 0);
        check("bp_next_wen", iss_wen, 4'b0010);
        access(0, 2'd0, 0, 17'h00201, 32'h0, 0);
        check("b_ld_lane1", last_rdata, 32'h00000055);

        // Reset during CAPTURE of a load.
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 17'h00100; req_valid = 1'b1;
        model(0, 2'd2, 0, 17'h00100, 32'h0);
        @(posedge clk);
        #1;
        active = 1'b1; k = 1; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b0; active = 1'b0;
        #1;
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_ready", req_ready, 0);
        check("rst_mid_addr", mem_addr, 0);
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_valid", rsp_valid, 0);

        // Misaligned halfword store and reserved-size load.
        access(1, 2'd1, 0, 17'h00101, 32'h00005678, 0);
`ifdef SPRAM_LSU_MISALIGN_ERR_EN
        check("mis_st_wen", iss_wen, 4'b0000);
        check("mis_st_err", last_err, 1);
        check("mis_st_rdata", last_rdata, 0);
        access(0, 2'd2, 0, 17'h00100, 32'h0, 0);
        check("mis_word_after", last_rdata, 32'h80ADBEEF);
        access(0, 2'd3, 1, 17'h00102, 32'h0, 0);
        check("rsv_err", last_err, 1);
        check("rsv_rdata", last_rdata, 0);
`else
        check("mis_st_wen", iss_wen, 4'b0011);
        check("mis_st_wdata", iss_wdata, 32'h56785678);
        check("mis_st_err", last_err, 0);
        access(0, 2'd2, 0, 17'h00100, 32'h0, 0);
        check("mis_word_after", last_rdata, 32'h80AD5678);
        access(0, 2'd3, 1, 17'h00102, 32'h0, 0);
        check("rsv_err", last_err, 0);
        check("rsv_rdata", last_rdata, 32'h80AD5678);
        access(0, 2'd2, 0, 17'h00203, 32'h0, 0);
        check("mis_w_ld", last_rdata, 32'h123455DD);
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
